load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the execute stage and data memory.
- Takes a store operand from register-file read port 2 and returns sign- or zero-extended load results on the register-file write port.
- Performs byte/halfword/word alignment, byte-enable generation and misalignment checking.
- Uses a simple req/ready + rvalid memory handshake.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32; other values unsupported.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  1  core requests an access; sampled only when busy_o=0
- we_i  in  1  1=store, 0=load
- size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  ADDR_W  effective byte address
- store_data_i  in  32  store operand (register-file read_data2)
- rd_addr_i  in  5  load destination register
- busy_o  out  1  high while state≠IDLE; core stalls
- done_o  out  1  one-cycle pulse on completion of any access
- err_o  out  1  one-cycle pulse on misaligned or illegal request
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_W  word-aligned address (addr[1:0]=00)
- mem_wdata_o  out  32  aligned store data
- mem_ready_i  in  1  memory accepts request this cycle
- mem_rdata_i  in  32  read data word
- mem_rvalid_i  in  1  read data valid
- rf_we_o  out  1  register-file write enable, one-cycle pulse
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  extended load result

Behaviour:
- Reset (async, rstn_i=0): state=IDLE. All outputs 0 immediately, including mem_req_o dropped mid-transaction. Internal registers cleared. No pending response is remembered after reset.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - req_i=1 with legal size and aligned address: latch we, size, addr, aligned wdata, be and rd; go to REQ.
  - req_i=1 with illegal size or misalignment: err_o=1 next cycle; stay IDLE; no memory access.
- Illegal requests:
  - Illegal size: 011, 11x, or BU/HU with we_i=1.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
- REQ:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o stable from registers.
  - On mem_ready_i=1: a store goes to IDLE with done_o=1 in the following cycle; a load goes to WAIT.
  - mem_rvalid_i is ignored in REQ.
- WAIT: on mem_rvalid_i=1, capture the extended result and go to WB. Waits indefinitely otherwise.
- WB:
  - rf_we_o=1 for exactly one cycle, with rf_waddr_o=rd and rf_wdata_o=result; done_o=1 in the same cycle; next state IDLE.
  - rf_we_o is suppressed when rd=0, but done_o still pulses.
- Store alignment:
  - SB: be=0001<<addr[1:0]; wdata = byte replicated x4.
  - SH: be=0011 (addr[1]=0) or 1100; wdata = halfword replicated x2.
  - SW: be=1111; wdata = store_data_i.
- Loads: mem_be_o=1111. Extract (rdata >> 8*addr[1:0]), then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
- Latency:
  - Store: minimum 2 cycles from acceptance to done_o.
  - Load: minimum 3 cycles from acceptance to rf_we_o. Example: accept c0, ready c1, rvalid c2, WB c3.
- Back-to-back: a new request is accepted the cycle busy_o returns to 0. req_i during busy_o=1 is ignored; the core must hold it.
- done_o and err_o are never asserted together.

Decomposition:
- lsu_pkg:
  - Enum lsu_state_t {IDLE, REQ, WAIT, WB}.
  - funct3 constants SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
  - Function is_misaligned(size, addr[1:0]).
- Sub-module lsu_align (purely combinational):
  - Store path: size, addr[1:0], data → be, wdata.
  - Load path: size, addr[1:0], rdata → extended result.
  - Instantiated once in load_store_unit.

Test Plan:
- SB to 0x0000_0103 with data 0x1122_33AB, mem_ready_i=1 in the first REQ cycle → mem_addr_o=0x100, mem_be_o=1000, mem_wdata_o=0xABAB_ABAB, mem_we_o=1; done_o 2 cycles after accept; rf_we_o never asserted.
- LB from 0x202, rd=5; mem_rdata_i=0x0080_0000 returned 1 cycle after ready → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xFFFF_FF80 exactly 3 cycles after accept. Repeat with LBU → 0x0000_0080.
- LH from 0x0000_0001 → err_o pulse next cycle; mem_req_o stays 0; busy_o stays 0. SW to 0x...2 → same. Size 011 → same.
- LW rd=0 with mem_ready_i delayed 3 cycles and rvalid delayed 4 → mem_req_o held with stable address through the stall; done_o pulses; rf_we_o stays 0.
- Reset asserted while in WAIT (mem_req_o already low) and again while in REQ → outputs 0 asynchronously; after release, busy_o=0; a stale mem_rvalid_i produces no rf_we_o.
- Back-to-back SW then LHU from 0x0000_0006 with rdata 0xBEEF_0000 → second request accepted the cycle busy_o falls; rf_wdata_o=0x0000_BEEF; a req_i pulse while busy_o=1 is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t     : FSM state encoding (IDLE, REQ, WAIT, WB)
//   SZ_*            : RISC-V funct3 access-size codes
//   is_misaligned   : address alignment check for a given access size
//   is_illegal_size : rejects unknown sizes and unsigned stores
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Halfwords need an even address, words need a 4-byte boundary.
  // Unknown sizes report aligned; they are caught by is_illegal_size.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_H, SZ_HU: mis = addr_lo[0];
      SZ_W:        mis = |addr_lo;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic is_illegal_size(input logic [2:0] size, input logic we);
    logic ill;
    case (size)
      SZ_B, SZ_H, SZ_W: ill = 1'b0;
      SZ_BU, SZ_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational alignment logic for the load/store unit.
//   Store path: st_size_i, st_addr_lo_i, st_data_i -> st_be_o, st_wdata_o
//               (byte lanes replicated so the enabled lanes carry the operand)
//   Load path : ld_size_i, ld_addr_lo_i, ld_rdata_i -> ld_result_o
//               (selected lane shifted down, then sign- or zero-extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_result_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SZ_B: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_shifted  = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
    ld_result_o = ld_shifted;
    case (ld_size_i)
      SZ_B:    ld_result_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_BU:   ld_result_o = {24'h0, ld_shifted[7:0]};
      SZ_H:    ld_result_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_HU:   ld_result_o = {16'h0, ld_shifted[15:0]};
      default: ld_result_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between execute and data memory.
//   Core side   : req_i/we_i/size_i/addr_i/store_data_i/rd_addr_i in,
//                 busy_o (stall), done_o and err_o one-cycle pulses out
//   Memory side : mem_req_o held until mem_ready_i; mem_we_o, mem_be_o,
//                 mem_addr_o (word aligned), mem_wdata_o; read data returns
//                 on mem_rdata_i qualified by mem_rvalid_i
//   Reg file    : rf_we_o pulse with rf_waddr_o / rf_wdata_o (extended load)
// Requests are only sampled in IDLE; illegal or misaligned ones raise err_o
// the next cycle without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_result;

  // Store path works on the incoming request; load path on the latched one.
  lsu_align u_align (
    .st_size_i    (size_i),
    .st_addr_lo_i (addr_i[1:0]),
    .st_data_i    (store_data_i),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_size_i    (size_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_rdata_i   (mem_rdata_i),
    .ld_result_o  (ld_result)
  );

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      rd_q     <= 5'd0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rd_d     = rd_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (is_illegal_size(size_i, we_i) || is_misaligned(size_i, addr_i[1:0])) begin
            err_d = 1'b1;
          end else begin
            we_d    = we_i;
            size_d  = size_i;
            addr_d  = addr_i;
            rd_d    = rd_addr_i;
            // Loads fetch the whole word and extract the lane on return.
            be_d    = we_i ? st_be : 4'b1111;
            wdata_d = we_i ? st_wdata : '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          result_d = ld_result;
          state_d  = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; memory and register-file buses read zero outside their states
  always_comb begin
    busy_o      = (state_q != IDLE);
    // Store completion comes from done_q, load completion from WB.
    done_o      = done_q | (state_q == WB);
    err_o       = err_q;
    mem_req_o   = (state_q == REQ);
    mem_we_o    = (state_q == REQ) && we_q;
    mem_be_o    = (state_q == REQ) ? be_q : 4'b0000;
    mem_addr_o  = (state_q == REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata_o = (state_q == REQ) ? wdata_q : '0;
    // x0 is hardwired to zero, so the write is dropped but done_o still fires.
    rf_we_o     = (state_q == WB) && (rd_q != 5'd0);
    rf_waddr_o  = (state_q == WB) ? rd_q : 5'd0;
    rf_wdata_o  = (state_q == WB) ? result_q : '0;
  end

endmodule
